// File: rtl/noc_pkg.sv
// Shared NoC constants: packet/flit geometry and packet field offsets.
// Also holds the ejection serializer FSM state type.
package noc_pkg;

  localparam int packet_size      = 32;
  localparam int flit_size        = 4;
  localparam int FLITS_PER_PACKET = packet_size / flit_size;

  localparam int x_address_length = 8;
  localparam int y_address_length = 8;
  localparam int axon_field_base  =
    x_address_length + y_address_length;

  typedef enum logic {
    EJ_IDLE = 1'b0,
    EJ_SEND = 1'b1
  } ej_state_e;

endpackage

// File: rtl/eject_flit_serializer.sv
// Ejection stage: takes one packet over valid/ready and writes it to the
// spike buffer LS flit first. Ports: router_clk/router_reset (sync, high),
// packet_in/packet_valid/packet_ready, neuron_full, data_out/write_en,
// busy (packet in flight), packet_count (packets fully written, wraps).
module eject_flit_serializer
  import noc_pkg::*;
#(
  parameter int packet_size        = noc_pkg::packet_size,
  parameter int flit_size          = noc_pkg::flit_size,
  parameter int FLITS_PER_PACKET   = packet_size / flit_size,
  parameter int FLIT_CNT_BIT_WIDTH = $clog2(FLITS_PER_PACKET),
  parameter int PKT_CNT_BIT_WIDTH  = 16
) (
  input  logic                         router_clk,
  input  logic                         router_reset,
  input  logic [packet_size-1:0]       packet_in,
  input  logic                         packet_valid,
  output logic                         packet_ready,
  input  logic                         neuron_full,
  output logic [flit_size-1:0]         data_out,
  output logic                         write_en,
  output logic                         busy,
  output logic [PKT_CNT_BIT_WIDTH-1:0] packet_count
);

  localparam logic [FLIT_CNT_BIT_WIDTH-1:0] LAST_IDX =
    FLIT_CNT_BIT_WIDTH'(FLITS_PER_PACKET - 1);

  ej_state_e                     state_q, state_d;
  logic [packet_size-1:0]        pkt_sr_q, pkt_sr_d;
  logic [FLIT_CNT_BIT_WIDTH-1:0] flit_idx_q, flit_idx_d;
  logic [PKT_CNT_BIT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic sending;
  logic last_flit;
  logic accept;

  always_comb begin
    state_d      = state_q;
    pkt_sr_d     = pkt_sr_q;
    flit_idx_d   = flit_idx_q;
    pkt_cnt_d    = pkt_cnt_q;

    sending      = (state_q == EJ_SEND);
    last_flit    = (flit_idx_q == LAST_IDX);
    write_en     = sending & ~neuron_full;
    // Reload is only allowed when the last flit actually leaves,
    // so a full buffer on the last flit back-pressures upstream.
    packet_ready = ~sending | (last_flit & ~neuron_full);
    accept       = packet_valid & packet_ready;

    if (write_en) begin
      pkt_sr_d   = pkt_sr_q >> flit_size;
      flit_idx_d = flit_idx_q + FLIT_CNT_BIT_WIDTH'(1);
      if (last_flit) begin
        pkt_cnt_d = pkt_cnt_q + PKT_CNT_BIT_WIDTH'(1);
        state_d   = EJ_IDLE;
      end
    end

    // Accept wins over the shift so back-to-back packets stream.
    if (accept) begin
      pkt_sr_d   = packet_in;
      flit_idx_d = '0;
      state_d    = EJ_SEND;
    end
  end

  always_ff @(posedge router_clk) begin
    if (router_reset) begin
      state_q    <= EJ_IDLE;
      pkt_sr_q   <= '0;
      flit_idx_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pkt_sr_q   <= pkt_sr_d;
      flit_idx_q <= flit_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign data_out     = pkt_sr_q[flit_size-1:0];
  assign busy         = sending;
  assign packet_count = pkt_cnt_q;

endmodule

// File: tb/tb_eject_flit_serializer.sv
// Directed bench for eject_flit_serializer: reset, single packet,
// back-to-back, stall, full on last flit, reset mid-packet.
module tb_eject_flit_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] packet_in;
  logic        packet_valid;
  logic        packet_ready;
  logic        neuron_full;
  logic [3:0]  data_out;
  logic        write_en;
  logic        busy;
  logic [15:0] packet_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eject_flit_serializer dut (
    .router_clk   (clk),
    .router_reset (rst),
    .packet_in    (packet_in),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .neuron_full  (neuron_full),
    .data_out     (data_out),
    .write_en     (write_en),
    .busy         (busy),
    .packet_count (packet_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    packet_in = 32'h0;
    packet_valid = 1'b0;
    neuron_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks += 5;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_we got=%b exp=0", write_en);
    end
    if (data_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", data_out);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (packet_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", packet_ready);
    end
    if (packet_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", packet_count);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_nib [8] = '{4'h8, 4'h7, 4'h6, 4'h5,
                                4'h4, 4'h3, 4'h2, 4'h1};
    packet_in = 32'h12345678;
    packet_valid = 1'b1;
    #1;
    checks++;
    if (packet_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got=%b exp=1", packet_ready);
    end
    tick();
    packet_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks += 3;
      if (write_en !== 1'b1) begin
        errors++;
        $display("FAIL single_we[%0d] got=%b exp=1", i, write_en);
      end
      if (data_out !== exp_nib[i]) begin
        errors++;
        $display("FAIL single_data[%0d] got=%h exp=%h",
                 i, data_out, exp_nib[i]);
      end
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL single_busy[%0d] got=%b exp=1", i, busy);
      end
      tick();
    end
    checks += 3;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL single_we_end got=%b exp=0", write_en);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end got=%b exp=0", busy);
    end
    if (packet_count !== 16'd1) begin
      errors++;
      $display("FAIL single_cnt got=%0d exp=1", packet_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d;
    logic       exp_r;
    packet_in = 32'hAAAAAAAA;
    packet_valid = 1'b1;
    tick();
    packet_in = 32'h55555555;
    for (int c = 0; c < 16; c++) begin
      exp_d = (c < 8) ? 4'hA : 4'h5;
      exp_r = (c == 7) || (c == 15);
      checks += 3;
      if (write_en !== 1'b1) begin
        errors++;
        $display("FAIL b2b_we[%0d] got=%b exp=1", c, write_en);
      end
      if (data_out !== exp_d) begin
        errors++;
        $display("FAIL b2b_data[%0d] got=%h exp=%h", c, data_out, exp_d);
      end
      if (packet_ready !== exp_r) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got=%b exp=%b",
                 c, packet_ready, exp_r);
      end
      tick();
      if (c == 7) packet_valid = 1'b0;
    end
    checks += 2;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_we_end got=%b exp=0", write_en);
    end
    if (packet_count !== 16'd3) begin
      errors++;
      $display("FAIL b2b_cnt got=%0d exp=3", packet_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pkt = 32'h87654321;
    logic [3:0]  exp_d;
    logic        full;
    int          k = 0;
    packet_in = pkt;
    packet_valid = 1'b1;
    tick();
    packet_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      full = (c >= 2) && (c <= 4);
      neuron_full = full;
      #1;
      exp_d = pkt[4*k +: 4];
      checks += 2;
      if (write_en !== !full) begin
        errors++;
        $display("FAIL stall_we[%0d] got=%b exp=%b", c, write_en, !full);
      end
      if (data_out !== exp_d) begin
        errors++;
        $display("FAIL stall_data[%0d] got=%h exp=%h", c, data_out, exp_d);
      end
      if (!full) k++;
      tick();
    end
    neuron_full = 1'b0;
    #1;
    checks += 2;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_we_end got=%b exp=0", write_en);
    end
    if (packet_count !== 16'd4) begin
      errors++;
      $display("FAIL stall_cnt got=%0d exp=4", packet_count);
    end
  endtask

  task automatic test_full_last();
    logic [31:0] p0 = 32'hCAFEBABE;
    logic [31:0] p1 = 32'h13579BDF;
    logic [63:0] stream;
    logic [3:0]  exp_d;
    logic        full;
    logic        exp_r;
    int          k = 0;
    stream = {p1, p0};
    packet_in = p0;
    packet_valid = 1'b1;
    tick();
    packet_in = p1;
    for (int c = 0; c < 18; c++) begin
      full = (c == 7) || (c == 8);
      neuron_full = full;
      #1;
      exp_d = stream[4*k +: 4];
      exp_r = !full && ((k == 7) || (k == 15));
      checks += 3;
      if (write_en !== !full) begin
        errors++;
        $display("FAIL flast_we[%0d] got=%b exp=%b", c, write_en, !full);
      end
      if (data_out !== exp_d) begin
        errors++;
        $display("FAIL flast_data[%0d] got=%h exp=%h", c, data_out, exp_d);
      end
      if (packet_ready !== exp_r) begin
        errors++;
        $display("FAIL flast_ready[%0d] got=%b exp=%b",
                 c, packet_ready, exp_r);
      end
      if (!full) k++;
      tick();
      if (k == 8) packet_valid = 1'b0;
    end
    neuron_full = 1'b0;
    #1;
    checks += 2;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL flast_we_end got=%b exp=0", write_en);
    end
    if (packet_count !== 16'd6) begin
      errors++;
      $display("FAIL flast_cnt got=%0d exp=6", packet_count);
    end
  endtask

  task automatic test_reset_mid();
    packet_in = 32'h9ABCDEF0;
    packet_valid = 1'b1;
    tick();
    packet_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks += 4;
    if (write_en !== 1'b0) begin
      errors++;
      $display("FAIL rmid_we got=%b exp=0", write_en);
    end
    if (packet_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ready got=%b exp=1", packet_ready);
    end
    if (packet_count !== 16'd0) begin
      errors++;
      $display("FAIL rmid_cnt got=%0d exp=0", packet_count);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_busy got=%b exp=0", busy);
    end
    packet_in = 32'h76543210;
    packet_valid = 1'b1;
    tick();
    packet_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (write_en !== 1'b1) begin
        errors++;
        $display("FAIL rmid_next_we[%0d] got=%b exp=1", i, write_en);
      end
      if (data_out !== 4'(i)) begin
        errors++;
        $display("FAIL rmid_next_data[%0d] got=%h exp=%h",
                 i, data_out, 4'(i));
      end
      tick();
    end
    checks++;
    if (packet_count !== 16'd1) begin
      errors++;
      $display("FAIL rmid_next_cnt got=%0d exp=1", packet_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_full_last();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
